// File: rtl/fifo_byte_unpack_if.sv
// Bundle of the FIFO read port and the byte-stream port of fifo_byte_unpack.
// FIFO_BYTE_UNPACK_PARITY_EN adds out_parity to the bundle.
interface fifo_byte_unpack_if;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
`ifdef FIFO_BYTE_UNPACK_PARITY_EN
    logic        out_parity;
`endif

    // Unpacker side: consumes the FIFO head, drives the byte stream
    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last,
`ifdef FIFO_BYTE_UNPACK_PARITY_EN
        output out_parity,
`endif
        output busy
    );

    // Environment side: FIFO plus byte sink
    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last,
`ifdef FIFO_BYTE_UNPACK_PARITY_EN
        input  out_parity,
`endif
        input  busy
    );
endinterface

// File: rtl/fifo_byte_unpack.sv
// Pops 32-bit words from a first-word-fall-through FIFO and streams them as four bytes.
// Optional even parity output enabled by defining FIFO_BYTE_UNPACK_PARITY_EN.
module fifo_byte_unpack #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_byte_unpack_if.master    bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    logic [WORD_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;
    logic              r_full;

    logic              w_accept;
    logic              w_last_beat;
    logic              w_load;
    logic [BYTE_W-1:0] w_byte;

    assign w_accept    = r_full & bus.out_ready;
    assign w_last_beat = (r_idx == IDX_W'(3));
    // Next word is popped as the last byte leaves, so words follow with no bubble
    assign w_load      = ~bus.fifo_empty & ~rst & (~r_full | (w_accept & w_last_beat));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_load) begin
            r_sreg <= bus.fifo_dout;
            r_idx  <= '0;
            r_full <= 1'b1;
        end else if (w_accept) begin
            if (w_last_beat) begin
                r_full <= 1'b0;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_sreg <= LSB_FIRST ? {BYTE_W'(0), r_sreg[WORD_W-1:BYTE_W]}
                                    : {r_sreg[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            end
        end
    end

    assign w_byte         = LSB_FIRST ? r_sreg[BYTE_W-1:0] : r_sreg[WORD_W-1:WORD_W-BYTE_W];
    assign bus.out_data   = w_byte;
    assign bus.out_valid  = r_full;
    assign bus.busy       = r_full;
    assign bus.out_last   = r_full & w_last_beat;
    assign bus.fifo_rd_en = w_load;

`ifdef FIFO_BYTE_UNPACK_PARITY_EN
    assign bus.out_parity = r_full & (^w_byte);
`endif
endmodule

// File: tb/tb_fifo_byte_unpack.sv
// Self-checking bench: both byte orders driven from one FIFO model and checked against byte queues.
// Parity checks are active when FIFO_BYTE_UNPACK_PARITY_EN is defined.
module tb_fifo_byte_unpack;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_byte_unpack_if bl();
    fifo_byte_unpack_if bm();

    fifo_byte_unpack #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
    fifo_byte_unpack #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bm));

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] fq[$];
    logic [7:0]  ql[$];
    logic [7:0]  qm[$];
    bit          just_rst = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the reference model
    task automatic tick(input bit rdy, input bit rs);
        bit          emp;
        bit          exp_load;
        logic [31:0] w;
        emp = (fq.size() == 0);
        w   = emp ? 32'($urandom) : fq[0];
        rst = rs;
        bl.out_ready = rdy;  bm.out_ready = rdy;
        bl.fifo_empty = emp; bm.fifo_empty = emp;
        bl.fifo_dout = w;    bm.fifo_dout = w;
        exp_load = !emp && !rs && (ql.size() == 0 || (rdy && ql.size() == 1));
        #1;
        chk("rd_en_lsb", 32'(bl.fifo_rd_en), 32'(exp_load));
        chk("rd_en_msb", 32'(bm.fifo_rd_en), 32'(exp_load));
        chk("valid_lsb", 32'(bl.out_valid), 32'(ql.size() != 0));
        chk("valid_msb", 32'(bm.out_valid), 32'(qm.size() != 0));
        chk("busy_lsb", 32'(bl.busy), 32'(ql.size() != 0));
        chk("busy_msb", 32'(bm.busy), 32'(qm.size() != 0));
        chk("last_lsb", 32'(bl.out_last), 32'(ql.size() == 1));
        chk("last_msb", 32'(bm.out_last), 32'(qm.size() == 1));
        if (ql.size() != 0) chk("data_lsb", 32'(bl.out_data), 32'(ql[0]));
        if (qm.size() != 0) chk("data_msb", 32'(bm.out_data), 32'(qm[0]));
        if (just_rst) begin
            chk("rstdata_lsb", 32'(bl.out_data), 32'h0);
            chk("rstdata_msb", 32'(bm.out_data), 32'h0);
        end
`ifdef FIFO_BYTE_UNPACK_PARITY_EN
        chk("par_lsb", 32'(bl.out_parity), (ql.size() != 0) ? 32'(^ql[0]) : 32'h0);
        chk("par_msb", 32'(bm.out_parity), (qm.size() != 0) ? 32'(^qm[0]) : 32'h0);
`endif
        @(posedge clk);
        if (rs) begin
            ql.delete();
            qm.delete();
        end else begin
            if (rdy && ql.size() != 0) void'(ql.pop_front());
            if (rdy && qm.size() != 0) void'(qm.pop_front());
            if (exp_load) begin
                for (int i = 0; i < 4; i++) begin
                    ql.push_back(w[8*i +: 8]);
                    qm.push_back(w[8*(3-i) +: 8]);
                end
                void'(fq.pop_front());
            end
        end
        just_rst = rs;
        @(negedge clk);
    endtask

    initial begin
        bl.out_ready = 1'b0; bm.out_ready = 1'b0;
        bl.fifo_empty = 1'b1; bm.fifo_empty = 1'b1;
        bl.fifo_dout = '0;   bm.fifo_dout = '0;
        @(negedge clk);

        // Reset with a word waiting: no pop while reset is held
        tick(1'b1, 1'b1);
        fq.push_back(32'h44332211);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        // Single word, no backpressure
        repeat (7) tick(1'b1, 1'b0);

        // Two words back to back
        fq.push_back(32'hA1B2C3D4);
        fq.push_back(32'h01020304);
        repeat (11) tick(1'b1, 1'b0);

        // Backpressure after byte 1 appears
        fq.push_back(32'h44332211);
        repeat (2) tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);

        // Reset mid-word with a second word queued
        fq.push_back(32'h44332211);
        fq.push_back(32'h55667788);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (7) tick(1'b1, 1'b0);

        // Parity pattern word, then idle
        fq.push_back(32'h00FF0107);
        repeat (8) tick(1'b1, 1'b0);

        // Random traffic, backpressure and occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3 && fq.size() < 8) fq.push_back(32'($urandom));
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end

        // Drain what is left
        repeat (40) tick(1'b1, 1'b0);
        chk("drained_fifo", 32'(fq.size()), 32'h0);
        chk("drained_bytes", 32'(ql.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_byte_unpack.md
# fifo_byte_unpack

Downstream drain stage for the 32-bit synchronous FIFO. Pops one word at a time from the FIFO's first-word-fall-through read port and streams it out as four 8-bit beats on a valid/ready byte interface. Byte ordering is selected by a parameter. Word-to-word transfer has no bubbles, so a full FIFO drains at one byte per clock under no backpressure.

## Interface
- `LSB_FIRST`, default 1: 1 emits `din[7:0]` first; 0 emits `din[31:24]` first.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `fifo_dout` input 32: FIFO head word, valid whenever `fifo_empty`=0.
- `fifo_empty` input 1: FIFO empty flag, registered by the FIFO.
- `fifo_rd_en` output 1: pop strobe to the FIFO, one cycle per word.
- `out_data` output 8: current byte.
- `out_valid` output 1: `out_data`/`out_last` valid.
- `out_ready` input 1: sink accepts the byte when `out_valid`=1 in the same cycle.
- `out_last` output 1: high on the 4th byte of each word.
- `busy` output 1: word held in the shift register (equals `out_valid`).
- `out_parity` output 1: even parity of `out_data`. Present only with `FIFO_BYTE_UNPACK_PARITY_EN`.

## Operation
- State: 32-bit shift register `sreg`, 2-bit byte index `idx`, flag `full`.
- Define `accept = out_valid & out_ready`.
- Define `load = ~fifo_empty & ~rst & (~full | (accept & idx==3))`.
- `fifo_rd_en = load`. This is combinational and is the only FIFO control.
- On `load`:
  - `sreg <= fifo_dout`, `idx <= 0`, `full <= 1`.
  - `fifo_dout` is sampled only in this cycle.
- On `accept` with `idx<3` (and no `load`):
  - `idx <= idx+1`.
  - `sreg` shifts 8 bits toward the output byte lane: right if `LSB_FIRST`, left otherwise.
- On `accept` with `idx==3` and no `load`: `full <= 0`.
- `out_data` = `sreg[7:0]` (`LSB_FIRST`=1) or `sreg[31:24]` (0).
- `out_valid` = `full`.
- `out_last` = `full & idx==3`.
- Backpressure: while `out_valid & ~out_ready`, the following hold stable:
  - `out_data`, `out_last`, `idx`, `sreg`.
  - `fifo_rd_en` stays 0.
- FIFO empty at a word boundary: after the last byte is accepted, `out_valid` goes low on the next edge. The block then waits in the empty condition.
- Reset mid-word: the partially sent word is discarded and no byte is replayed. Any word already popped is lost, which is intentional.
- No other states exist: the state is idle (`full`=0) or sending (`full`=1, `idx` 0..3).

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `busy`=0.
  - `out_data`=8'h00 (`sreg`=0), `idx`=0, `full`=0.
  - `fifo_rd_en`=0 while `rst`=1.
  - `out_parity`=0.
- Latency: `fifo_empty` falls at cycle N, so `fifo_rd_en`=1 in cycle N and byte 0 is valid in cycle N+1.
- Throughput: with `out_ready` held at 1, 4 bytes per word, back-to-back.
  - The pop for word k+1 coincides with acceptance of byte 3 of word k.
  - `fifo_rd_en` pulses every 4th cycle.
- `fifo_rd_en` is never asserted while `fifo_empty`=1, so the FIFO is never underflowed.
- `fifo_rd_en` is at most one pulse per cycle and is never high in two consecutive cycles.

## Configuration
- `FIFO_BYTE_UNPACK_PARITY_EN`
  - Defined: the `out_parity` port exists and equals `^out_data`. It is gated to 0 when `out_valid`=0 and holds with the data under backpressure.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, `LSB_FIRST`=1, FIFO holds 32'h44332211, `out_ready`=1:
  - `fifo_rd_en` pulses once.
  - Bytes 11, 22, 33, 44 appear in 4 consecutive cycles.
  - `out_last` is high only on 44.
- `LSB_FIRST`=0, same word: bytes 44, 33, 22, 11 with `out_last` on 11.
- Two words, A1B2C3D4 then 01020304, `out_ready`=1:
  - 8 bytes in 8 consecutive cycles with no gap.
  - `fifo_rd_en` high in cycle 0 and cycle 4 only.
- Backpressure: `out_ready`=0 for 5 cycles after byte 1 (22) appears.
  - `out_data` stays 22, `idx` stays 1, `fifo_rd_en` stays 0.
  - When `out_ready` returns, 33 and 44 follow.
- Reset after byte 2 of 32'h44332211 with a second word queued:
  - Next cycle `out_valid`=0.
  - After release, the queued word starts at its byte 0.
- `FIFO_BYTE_UNPACK_PARITY_EN` defined, word 32'h00FF0107:
  - `out_parity` is 1, 1, 0, 0 for bytes 07, 01, FF, 00.
  - `out_parity` is 0 while idle.
